// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment display controller.
//   SEG_A..SEG_G : bit positions of each segment on the {g,f,e,d,c,b,a} bus
//   SEG_OFF      : all segments dark
//   scan_state_t : scan FSM states
package seg7_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] SEG_OFF = 7'h00;

    typedef enum logic {
        ON  = 1'b0,
        GAP = 1'b1
    } scan_state_t;

endpackage

// File: rtl/hex2seg7.sv
// Hex nibble to 7-segment decoder (combinational).
//   nibble_i : hex value 0..F
//   seg_o    : {g,f,e,d,c,b,a}, active-high
module hex2seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        unique case (nibble_i)
            4'h0: seg_o = 7'h3F;
            4'h1: seg_o = 7'h06;
            4'h2: seg_o = 7'h5B;
            4'h3: seg_o = 7'h4F;
            4'h4: seg_o = 7'h66;
            4'h5: seg_o = 7'h6D;
            4'h6: seg_o = 7'h7D;
            4'h7: seg_o = 7'h07;
            4'h8: seg_o = 7'h7F;
            4'h9: seg_o = 7'h6F;
            4'hA: seg_o = 7'h77;
            4'hB: seg_o = 7'h7C;
            4'hC: seg_o = 7'h39;
            4'hD: seg_o = 7'h5E;
            4'hE: seg_o = 7'h79;
            4'hF: seg_o = 7'h71;
            default: seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan_controller.sv
// Time-multiplexed N-digit common-cathode 7-segment controller.
//   clk, rst_n     : system clock, async active-low reset
//   wr_en/addr/... : per-digit register file write port (nibble + dp)
//   blank          : force outputs dark, scan keeps running
//   lz_suppress    : blank leading zero digits (digit 0 never blanked)
//   segments, dp   : shared segment bus, registered
//   digit_en       : one-hot digit enable, registered with the bus
//   frame_start    : pulse when digit 0 becomes enabled
//
// state | meaning
// ON    | digit idx enabled for DWELL_CYCLES clocks
// GAP   | all digits off for GAP_CYCLES clocks (unused when GAP_CYCLES = 0)
module seg7_scan_controller
    import seg7_pkg::*;
#(
    parameter  int NUM_DIGITS   = 4,
    parameter  int DWELL_CYCLES = 4,
    parameter  int GAP_CYCLES   = 1,
    localparam int AW           = $clog2(NUM_DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [3:0]            wr_data,
    input  logic                  wr_dp,
    input  logic                  blank,
    input  logic                  lz_suppress,
    output logic [6:0]            segments,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] digit_en,
    output logic                  frame_start
);

    localparam int MAXC = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [AW-1:0] IDX_LAST   = AW'(NUM_DIGITS - 1);

    logic [3:0]            nib_q [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] dpr_q;

    scan_state_t           state_q, state_d;
    logic [AW-1:0]         idx_q, idx_d, idx_next;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic [6:0]            dec_seg;
    logic [NUM_DIGITS-1:0] upper_zero;

    logic [6:0]            segments_q, segments_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
    logic                  frame_start_q, frame_start_d;

    // Register file; addresses beyond NUM_DIGITS-1 match no entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) nib_q[i] <= 4'h0;
            dpr_q <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (wr_addr == AW'(i)) begin
                    nib_q[i] <= wr_data;
                    dpr_q[i] <= wr_dp;
                end
            end
        end
    end

    hex2seg7 u_hex2seg7 (
        .nibble_i (nib_q[idx_q]),
        .seg_o    (dec_seg)
    );

    // upper_zero[i]: digits i..NUM_DIGITS-1 all hold 0.
    always_comb begin
        logic z;
        upper_zero = '0;
        z = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            z = z & (nib_q[i] == 4'h0);
            upper_zero[i] = z;
        end
    end

    assign idx_next = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + 1'b1;
        unique case (state_q)
            ON: begin
                if (cnt_q == DWELL_LAST) begin
                    cnt_d = '0;
                    if (GAP_CYCLES == 0) idx_d = idx_next;
                    else                 state_d = GAP;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = ON;
                    idx_d   = idx_next;
                end
            end
            default: begin
                state_d = ON;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Output stage samples the current scan position, so bus and enable
    // change together one edge after the FSM reaches a position.
    always_comb begin
        segments_d    = SEG_OFF;
        dp_d          = 1'b0;
        digit_en_d    = '0;
        frame_start_d = (state_q == ON) && (idx_q == '0) && (cnt_q == '0);
        if (state_q == ON && !blank) begin
            digit_en_d = NUM_DIGITS'(1) << idx_q;
            dp_d       = dpr_q[idx_q];
            if (lz_suppress && idx_q != '0 && upper_zero[idx_q])
                segments_d = SEG_OFF;
            else
                segments_d = dec_seg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ON;
            idx_q         <= '0;
            cnt_q         <= '0;
            segments_q    <= SEG_OFF;
            dp_q          <= 1'b0;
            digit_en_q    <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            segments_q    <= segments_d;
            dp_q          <= dp_d;
            digit_en_q    <= digit_en_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign segments    = segments_q;
    assign dp          = dp_q;
    assign digit_en    = digit_en_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
module tb_seg7_scan_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [2:0] wr_addr5;
    logic [3:0] wr_data;
    logic       wr_dp;
    logic       blank;
    logic       lz_suppress;

    logic [6:0] seg,  seg0,  seg5;
    logic       dp,   dp0,   dp5;
    logic [3:0] en,   en0;
    logic [4:0] en5;
    logic       fs,   fs0,   fs5;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    // Default configuration: 4 digits, dwell 4, gap 1.
    seg7_scan_controller #(.NUM_DIGITS(4), .DWELL_CYCLES(4), .GAP_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_dp(wr_dp), .blank(blank), .lz_suppress(lz_suppress),
        .segments(seg), .dp(dp), .digit_en(en), .frame_start(fs));

    // No gap state.
    seg7_scan_controller #(.NUM_DIGITS(4), .DWELL_CYCLES(4), .GAP_CYCLES(0)) dut_g0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_dp(wr_dp), .blank(blank), .lz_suppress(lz_suppress),
        .segments(seg0), .dp(dp0), .digit_en(en0), .frame_start(fs0));

    // Five digits: 3-bit address can express out-of-range indices 5..7.
    seg7_scan_controller #(.NUM_DIGITS(5), .DWELL_CYCLES(4), .GAP_CYCLES(1)) dut_n5 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr5), .wr_data(wr_data),
        .wr_dp(wr_dp), .blank(blank), .lz_suppress(lz_suppress),
        .segments(seg5), .dp(dp5), .digit_en(en5), .frame_start(fs5));

    // Expected enable for a frame of 5-clock slots (4 on, 1 gap).
    function automatic logic [3:0] exp_en4(input int k);
        int p;
        p = k % 20;
        if (p % 5 == 4) return 4'b0000;
        return 4'(1 << (p / 5));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_addr = 2'd0; wr_addr5 = 3'd0; wr_data = 4'h0; wr_dp = 1'b0;
        blank = 1'b0; lz_suppress = 1'b0;
    endtask

    // Leaves us just after a negedge; the next posedge is scan edge 0.
    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = -1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [3:0] d, input logic p);
        wr_en = 1'b1; wr_addr = a[1:0]; wr_addr5 = a; wr_data = d; wr_dp = p;
        step();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if ({seg, dp, en, fs, seg0, en0, fs0, seg5, en5, fs5} !== '0) begin
            n_bad++;
            $display("FAIL reset_state got seg=%h dp=%b en=%b fs=%b want all 0", seg, dp, en, fs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc = -1;
        step();
        n_cmp++;
        if ({en, fs, seg, dp} !== {4'b0001, 1'b1, 7'h3F, 1'b0}) begin
            n_bad++;
            $display("FAIL first_edge got en=%b fs=%b seg=%h dp=%b want 0001 1 3f 0", en, fs, seg, dp);
        end
        n_cmp++;
        if ({en0, fs0, seg0} !== {4'b0001, 1'b1, 7'h3F}) begin
            n_bad++;
            $display("FAIL first_edge_g0 got en=%b fs=%b seg=%h want 0001 1 3f", en0, fs0, seg0);
        end
    endtask

    // Continues from test_reset: blank register file, both gap settings.
    task automatic test_scan();
        logic [3:0] e_en, e_en0;
        for (int k = 1; k < 45; k++) begin
            run_to(k);
            e_en = exp_en4(k);
            n_cmp++;
            if ({en, fs, seg, dp} !== {e_en, (k % 20 == 0), (e_en != 0) ? 7'h3F : 7'h00, 1'b0}) begin
                n_bad++;
                $display("FAIL scan k=%0d got en=%b fs=%b seg=%h dp=%b want en=%b fs=%b",
                         k, en, fs, seg, dp, e_en, (k % 20 == 0));
            end
            e_en0 = 4'(1 << ((k % 16) / 4));
            n_cmp++;
            if ({en0, fs0, seg0} !== {e_en0, (k % 16 == 0), 7'h3F}) begin
                n_bad++;
                $display("FAIL scan_gap0 k=%0d got en=%b fs=%b seg=%h want en=%b fs=%b seg=3f",
                         k, en0, fs0, seg0, e_en0, (k % 16 == 0));
            end
        end
    endtask

    task automatic test_write_digits();
        logic [6:0] tbl [4];
        logic [3:0] e_en;
        tbl[0] = 7'h71; tbl[1] = 7'h06; tbl[2] = 7'h77; tbl[3] = 7'h7F;
        do_reset();
        wr(3'd3, 4'h8, 1'b0);
        wr(3'd2, 4'hA, 1'b0);
        wr(3'd1, 4'h1, 1'b0);
        wr(3'd0, 4'hF, 1'b0);
        for (int k = 20; k < 40; k++) begin
            run_to(k);
            e_en = exp_en4(k);
            n_cmp++;
            if ({en, seg} !== {e_en, (e_en != 0) ? tbl[(k % 20) / 5] : 7'h00}) begin
                n_bad++;
                $display("FAIL write_digits k=%0d got en=%b seg=%h want en=%b seg=%h",
                         k, en, seg, e_en, (e_en != 0) ? tbl[(k % 20) / 5] : 7'h00);
            end
        end
        run_to(40);
        wr(3'd0, 4'h5, 1'b1);
        n_cmp++;
        if ({en, seg, dp} !== {4'b0001, 7'h71, 1'b0}) begin
            n_bad++;
            $display("FAIL write_latency_edgeN got en=%b seg=%h dp=%b want 0001 71 0", en, seg, dp);
        end
        step();
        n_cmp++;
        if ({en, seg, dp} !== {4'b0001, 7'h6D, 1'b1}) begin
            n_bad++;
            $display("FAIL write_latency_edgeN1 got en=%b seg=%h dp=%b want 0001 6d 1", en, seg, dp);
        end
    endtask

    task automatic test_lz();
        logic [6:0] tbl_lz [4];
        logic [6:0] tbl_no [4];
        logic [6:0] e_seg;
        logic [3:0] e_en;
        logic       e_dp;
        tbl_lz[0] = 7'h3F; tbl_lz[1] = 7'h06; tbl_lz[2] = 7'h00; tbl_lz[3] = 7'h00;
        tbl_no[0] = 7'h3F; tbl_no[1] = 7'h06; tbl_no[2] = 7'h3F; tbl_no[3] = 7'h3F;
        do_reset();
        lz_suppress = 1'b1;
        wr(3'd1, 4'h1, 1'b0);
        wr(3'd3, 4'h0, 1'b1);
        for (int k = 20; k < 60; k++) begin
            run_to(k);
            e_en  = exp_en4(k);
            e_seg = (e_en == 0) ? 7'h00 : (k < 40) ? tbl_lz[(k % 20) / 5] : tbl_no[(k % 20) / 5];
            e_dp  = (e_en == 4'b1000);
            n_cmp++;
            if ({en, seg, dp} !== {e_en, e_seg, e_dp}) begin
                n_bad++;
                $display("FAIL lz k=%0d got en=%b seg=%h dp=%b want en=%b seg=%h dp=%b",
                         k, en, seg, dp, e_en, e_seg, e_dp);
            end
            if (k == 39) lz_suppress = 1'b0;
        end
    endtask

    // Blank sampled on edges 17..23, spanning the frame_start at edge 20.
    task automatic test_blank();
        logic [3:0] e_en;
        logic       blanked;
        do_reset();
        for (int k = 0; k < 46; k++) begin
            run_to(k);
            blanked = (k >= 17 && k <= 23);
            e_en = blanked ? 4'b0000 : exp_en4(k);
            n_cmp++;
            if ({en, fs, seg, dp} !== {e_en, (k % 20 == 0), (e_en != 0) ? 7'h3F : 7'h00, 1'b0}) begin
                n_bad++;
                $display("FAIL blank k=%0d got en=%b fs=%b seg=%h dp=%b want en=%b fs=%b",
                         k, en, fs, seg, dp, e_en, (k % 20 == 0));
            end
            if (k == 16) blank = 1'b1;
            if (k == 23) blank = 1'b0;
        end
    endtask

    task automatic test_bad_addr();
        logic [4:0] e_en;
        logic [6:0] e_seg;
        int         p;
        do_reset();
        wr(3'd5, 4'h8, 1'b1);
        wr(3'd6, 4'h8, 1'b1);
        wr(3'd7, 4'h8, 1'b1);
        wr(3'd4, 4'h1, 1'b0);
        for (int k = 25; k < 50; k++) begin
            run_to(k);
            p = k % 25;
            e_en  = (p % 5 == 4) ? 5'b00000 : 5'(1 << (p / 5));
            e_seg = (e_en == 0) ? 7'h00 : (e_en == 5'b10000) ? 7'h06 : 7'h3F;
            n_cmp++;
            if ({en5, fs5, seg5, dp5} !== {e_en, (p == 0), e_seg, 1'b0}) begin
                n_bad++;
                $display("FAIL bad_addr k=%0d got en=%b fs=%b seg=%h dp=%b want en=%b fs=%b seg=%h dp=0",
                         k, en5, fs5, seg5, dp5, e_en, (p == 0), e_seg);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] e_en;
        do_reset();
        wr(3'd2, 4'hA, 1'b1);
        run_to(11);
        n_cmp++;
        if ({en, seg, dp} !== {4'b0100, 7'h77, 1'b1}) begin
            n_bad++;
            $display("FAIL mid_before got en=%b seg=%h dp=%b want 0100 77 1", en, seg, dp);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({en, seg, dp, fs} !== '0) begin
            n_bad++;
            $display("FAIL mid_async got en=%b seg=%h dp=%b fs=%b want all 0", en, seg, dp, fs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc = -1;
        for (int k = 0; k < 15; k++) begin
            run_to(k);
            e_en = exp_en4(k);
            n_cmp++;
            if ({en, fs, seg, dp} !== {e_en, (k == 0), (e_en != 0) ? 7'h3F : 7'h00, 1'b0}) begin
                n_bad++;
                $display("FAIL mid_restart k=%0d got en=%b fs=%b seg=%h dp=%b want en=%b seg=3f/00",
                         k, en, fs, seg, dp, e_en);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_write_digits();
        test_lz();
        test_blank();
        test_bad_addr();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
